// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction memory, fetch PC and prefetch FIFO feeding decode
// Optional performance counters are built when IF_PERF_EN is defined.
module instr_fetch_queue #(
  parameter int DATA_W             = 32,
  parameter int ADDR_W             = 32,
  parameter int MEM_DEPTH          = 256,
  parameter int QDEPTH             = 4,
  parameter int unsigned PC_STEP   = 1,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_redirect,
  input  logic [ADDR_W-1:0]         in_redirect_pc,
  input  logic                      in_halt,
  input  logic                      in_load_we,
  input  logic [ADDR_W-1:0]         in_load_addr,
  input  logic [DATA_W-1:0]         in_load_data,
  output logic                      out_valid,
  input  logic                      in_ready,
  output logic [DATA_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [ADDR_W-1:0]         out_fetch_pc,
  output logic [$clog2(QDEPTH):0]   out_count
`ifdef IF_PERF_EN
  ,
  output logic [31:0]               out_perf_issued,
  output logic [31:0]               out_perf_flushed
`endif
);

  localparam int MW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rdData;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] inflightPc;
  logic              inflight;

  logic [DATA_W-1:0] qInstr [QDEPTH];
  logic [ADDR_W-1:0] qPc [QDEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic              issue;
  logic              push;
  logic              pop;
  logic [CW:0]       occupancy;

  // Reserving a slot for the in-flight read keeps the FIFO from overflowing when it lands.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = !rst && !in_redirect && !in_halt && (occupancy < (CW+1)'(QDEPTH));
  assign push      = inflight && !rst && !in_redirect;
  assign pop       = out_valid && in_ready && !rst && !in_redirect;

  // Read and write never coincide (issue needs !halt, write needs halt); read-before-write holds anyway.
  always_ff @(posedge clk) begin
    if (in_load_we && in_halt) begin
      mem[MW'(in_load_addr)] <= in_load_data;
    end
    if (issue) begin
      rdData <= mem[MW'(fetchPc)];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qInstr[tail] <= rdData;
      qPc[tail]    <= inflightPc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc    <= ADDR_W'(RESET_PC);
      inflightPc <= '0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      inflight <= issue;
      if (in_redirect) begin
        fetchPc <= in_redirect_pc;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
      end else begin
        if (issue) begin
          fetchPc    <= fetchPc + ADDR_W'(PC_STEP);
          inflightPc <= fetchPc;
        end
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  assign out_valid    = (count != '0);
  assign out_instr    = out_valid ? qInstr[head] : '0;
  assign out_pc       = out_valid ? qPc[head] : '0;
  assign out_fetch_pc = fetchPc;
  assign out_count    = count;

`ifdef IF_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_perf_issued  <= '0;
      out_perf_flushed <= '0;
    end else begin
      if (issue) out_perf_issued <= out_perf_issued + 32'd1;
      if (in_redirect) out_perf_flushed <= out_perf_flushed + 32'(occupancy);
    end
  end
`endif

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised successor of the single-PC fetch stage.
- Holds a word-addressed instruction memory, a free-running fetch PC and a QDEPTH-entry prefetch FIFO.
- Hands {pc, instruction} pairs to decode over a valid/ready handshake.
- Supports branch redirect with flush, debug halt, and a debug memory-load port.
- Sits between the PC-select logic and the IF/ID boundary; decode back-pressure replaces the old IF_ID_write/PC_write stall pair.

Parameters:
- DATA_W, 32, instruction width
- ADDR_W, 32, PC width
- MEM_DEPTH, 256, instruction memory words (power of 2)
- QDEPTH, 4, prefetch FIFO entries (power of 2, >=2)
- PC_STEP, 1, PC increment per fetch (word addressing)
- RESET_PC, 0, fetch PC after reset

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_redirect  in  1  branch/jump taken; flush and restart fetch
- in_redirect_pc  in  ADDR_W  restart address
- in_halt  in  1  debug stop; no new fetches issued
- in_load_we  in  1  debug write to instruction memory
- in_load_addr  in  ADDR_W  debug write word address
- in_load_data  in  DATA_W  debug write data
- out_valid  out  1  FIFO head valid
- in_ready  in  1  decode accepts head
- out_instr  out  DATA_W  head instruction
- out_pc  out  ADDR_W  head instruction address
- out_fetch_pc  out  ADDR_W  next address to be issued
- out_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Reset (sync, rst=1 at posedge): fetch_pc=RESET_PC, FIFO empty, in-flight flag clear, out_count=0, out_valid=0. Memory contents are not reset.
- Memory: synchronous read, 1-cycle latency. Index = address[log2(MEM_DEPTH)-1:0]; out-of-range addresses wrap.
- Issue condition: !rst && !in_redirect && !in_halt && (count + inflight) < QDEPTH.
  - Issue reads mem[fetch_pc], records inflight_pc = fetch_pc, sets the in-flight flag, and sets fetch_pc += PC_STEP (mod 2^ADDR_W).
- Landing: the cycle after an issue, {inflight_pc, data} is pushed into the FIFO tail. At most one in flight at a time, so throughput is 1 instr/cycle when issuing back-to-back.
- Pop: on posedge when out_valid && in_ready. Push and pop in the same cycle are allowed; count is unchanged.
- Outputs are registered FIFO head. When empty: out_instr=0, out_pc=0, out_valid=0.
- Redirect (priority over everything except rst):
  - FIFO cleared, count=0.
  - In-flight result discarded.
  - Pop in that cycle ignored.
  - fetch_pc = in_redirect_pc.
  - No issue that cycle.
  - Latency: redirect at edge N, issue of the target at edge N+1, out_valid=1 with out_pc=target after edge N+2.
- Halt:
  - Blocks new issues only.
  - An in-flight read still lands.
  - Decode may keep draining.
  - Clearing halt resumes at the unchanged fetch_pc.
- Debug load:
  - Write is performed only when in_load_we && in_halt. Ignored otherwise.
  - A write to the address currently in flight does not alter that result (read-before-write).
- Full: count==QDEPTH blocks issue. count+inflight==QDEPTH also blocks, so the FIFO never overflows.
- Reset mid-operation: all queued and in-flight results are discarded and fetch restarts at RESET_PC.

Optional Feature:
- Macro IF_PERF_EN.
- Defined: adds ports out_perf_issued (out, 32) and out_perf_flushed (out, 32).
  - out_perf_issued counts issue cycles.
  - out_perf_flushed adds count+inflight on each redirect.
  - Both are 0 on reset and wrap at 2^32.
  - Neither counter increments during rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. Load mem[0..7]=0x100..0x107 under halt, release halt, in_ready=1 -> out_valid from cycle 2; out_pc 0,1,2... with out_instr 0x100,0x101,... one per cycle.
2. in_ready=0 after release -> out_count rises to 4 and holds; out_fetch_pc=4; no issue while full; in_ready=1 resumes and out_pc continues 0,1,2,3,4.
3. Full FIFO, in_redirect=1 with pc=0x20 (MEM_DEPTH=256) -> next cycle out_valid=0, count=0; two cycles later out_pc=0x20, out_instr=mem[0x20].
4. in_halt=1 while a fetch is in flight -> that entry lands, then no further issues and out_fetch_pc is frozen; in_load_we with in_halt=0 leaves memory unchanged.
5. fetch_pc=0xFF, MEM_DEPTH=256 -> next fetch reads mem[0x00], out_pc=0x100, subsequent out_fetch_pc=0x101.
6. rst asserted with 3 entries queued and 1 in flight -> after the edge out_valid=0, out_count=0, out_fetch_pc=RESET_PC; with IF_PERF_EN both counters read 0.
